// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store memory adapter: size codes, FSM states,
// and the lane mask / alignment helpers used by both control and datapath.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RESP
  } state_t;

  // Byte-enable style mask for the addressed lane(s); word accesses cover all lanes.
  function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] base;
    case (size)
      SZ_BYTE: base = 32'h0000_00FF;
      SZ_HALF: base = 32'h0000_FFFF;
      default: base = 32'hFFFF_FFFF;
    endcase
    return base << {lane, 3'b000};
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    logic bad;
    case (size)
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = (addr != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane datapath: extracts and extends sub-word load data and
// merges right-aligned store data into an existing memory word.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_data
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] mask;

  assign shamt   = {lane, 3'b000};
  assign shifted = mem_word >> shamt;
  assign mask    = lane_mask(size, lane);

  always_comb begin
    load_data = shifted;
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign merged_data = (mem_word & ~mask) | ((wdata << shamt) & mask);

endmodule

// File: rtl/mem_access_adapter.sv
// Load/store front-end for a word-addressed data memory: byte/half/word access,
// read-modify-write for sub-word stores, per-phase ack timeout.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready for a request; captures it on valid
// ST_RD_REQ  | one-cycle memory read enable
// ST_RD_WAIT | waiting for read ack (load result or RMW old word)
// ST_WR_REQ  | one-cycle memory write enable with final word
// ST_WR_WAIT | waiting for write ack
// ST_RESP    | one-cycle response pulse
module mem_access_adapter
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_rd_en_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [31:0]       load_data;
  logic [31:0]       merged_data;
  logic              req_bad;
  logic              timeout_hit;

  mem_lane_align u_align (
    .size        (size_q),
    .lane        (addr_q[1:0]),
    .is_unsigned (uns_q),
    .mem_word    (mem_data_i),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_data (merged_data)
  );

  assign req_bad     = (req_size_i == SZ_ILLEGAL) || misaligned(req_size_i, req_addr_i[1:0]);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d      = req_we_i;
          size_d    = req_size_i;
          uns_d     = req_unsigned_i;
          addr_d    = req_addr_i;
          wdata_d   = req_wdata_i;
          rdata_d   = '0;
          wr_data_d = req_wdata_i;
          cnt_d     = '0;
          err_d     = req_bad;
          if (req_bad)
            state_d = ST_RESP;
          else if (!req_we_i || req_size_i != SZ_WORD)
            state_d = ST_RD_REQ;
          else
            state_d = ST_WR_REQ;
        end
      end

      ST_RD_REQ: begin
        cnt_d   = '0;
        state_d = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        if (mem_ack_i) begin
          if (we_q) begin
            wr_data_d = merged_data;
            state_d   = ST_WR_REQ;
          end else begin
            rdata_d = load_data;
            state_d = ST_RESP;
          end
        end else if (timeout_hit) begin
          // An RMW store that times out here is abandoned before any write.
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WR_REQ: begin
        cnt_d   = '0;
        state_d = ST_WR_WAIT;
      end

      ST_WR_WAIT: begin
        if (mem_ack_i) begin
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Every output is a decode of registered state, never of a live input.
  assign req_ready_o  = (state_q == ST_IDLE);
  assign mem_rd_en_o  = (state_q == ST_RD_REQ);
  assign mem_wr_en_o  = (state_q == ST_WR_REQ);
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_err_o   = (state_q == ST_RESP) && err_q;
  assign resp_rdata_o = (state_q == ST_RESP) ? rdata_q : 32'h0;
  assign mem_addr_o   = {addr_q[31:2], 2'b00};
  assign mem_data_o   = wr_data_q;

endmodule

// File: tb/tb_mem_access_adapter.sv
// Scoreboard bench for mem_access_adapter: byte-level reference memory,
// behavioural memory slave, directed cases followed by random traffic.
module tb_mem_access_adapter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_o;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  mem_access_adapter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_uns),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err),
    .mem_rd_en_o    (mem_rd_en),
    .mem_wr_en_o    (mem_wr_en),
    .mem_addr_o     (mem_addr),
    .mem_data_o     (mem_data_o),
    .mem_data_i     (mem_rdata),
    .mem_ack_i      (mem_ack)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    int          rd_base;
    int          wr_base;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          resp_cnt = 0;
  logic [7:0]  ref_mem [256];
  logic [31:0] mem_words [64];
  bit          no_ack = 1'b0;
  bit          rnd_lat = 1'b0;
  int          fix_extra = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference load: gather bytes little-endian, then extend from the top byte read.
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int n, input bit uns);
    longint unsigned v = 0;
    logic [7:0] idx;
    for (int i = 0; i < n; i++) begin
      idx = addr[7:0] + 8'(i);
      v = v | (longint'(ref_mem[idx]) << (8 * i));
    end
    if (!uns && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] addr, input int n, input logic [31:0] wd);
    logic [7:0] idx;
    for (int i = 0; i < n; i++) begin
      idx = addr[7:0] + 8'(i);
      ref_mem[idx] = 8'(wd >> (8 * i));
    end
  endtask

  // Memory slave: samples enables on the falling edge, acks 1+extra cycles later.
  initial begin
    bit          pend;
    int          pend_dly;
    logic [31:0] pend_data;
    int          idx;
    pend = 0;
    pend_dly = 0;
    pend_data = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (pend) begin
        if (pend_dly == 0) begin
          mem_ack = 1'b1;
          mem_rdata = pend_data;
          pend = 0;
        end else begin
          pend_dly--;
        end
      end
      if (mem_rd_en || mem_wr_en) begin
        chk("dual_enable", 32'(mem_rd_en & mem_wr_en), 32'd0);
        chk("mem_addr_align", 32'({mem_addr[31:8], mem_addr[1:0]}), 32'd0);
        idx = int'(mem_addr[7:2]);
        if (mem_rd_en) rd_cnt++;
        if (mem_wr_en) wr_cnt++;
        if (!no_ack) begin
          if (mem_wr_en) mem_words[idx] = mem_data_o;
          pend = 1;
          pend_data = mem_words[idx];
          pend_dly = rnd_lat ? int'($urandom_range(0, 3)) : fix_extra;
        end
      end
    end
  end

  // Monitor: every response pulse is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        resp_cnt++;
        if (sb.size() == 0) begin
          fail_now("unexpected_resp");
        end else begin
          e = sb.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", 32'(resp_err), 32'(e.err));
          if (e.lat >= 0) chk("resp_latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
          chk("rd_enables", 32'(rd_cnt - e.rd_base), 32'(e.rd));
          chk("wr_enables", 32'(wr_cnt - e.wr_base), 32'(e.wr));
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   n;
    int   guard;
    bit   bad;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_uns   = uns;
    req_addr  = addr;
    req_wdata = wd;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      fail_now("accept_wait");
      req_valid = 1'b0;
      return;
    end
    n   = 1 << sz;
    bad = (sz == 2'b11) || ((addr % n) != 0);
    e.err = bad;
    e.rdata = '0;
    e.rd = 0;
    e.wr = 0;
    if (!bad) begin
      if (!we) begin
        e.rd = 1;
        if (!no_ack) e.rdata = ref_load(addr, n, uns);
      end else begin
        e.rd = (n != 4) ? 1 : 0;
        e.wr = (no_ack && n != 4) ? 0 : 1;
        if (!no_ack) ref_store(addr, n, wd);
      end
      if (no_ack) e.err = 1'b1;
    end
    if (bad)                          e.lat = 1;
    else if (no_ack)                  e.lat = 2 + TIMEOUT;
    else if (rnd_lat || fix_extra != 0) e.lat = -1;
    else                              e.lat = (we && n != 4) ? 5 : 3;
    e.rd_base = rd_cnt;
    e.wr_base = wr_cnt;
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      fail_now("drain");
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    int          r;
    int          rd_snap;
    int          wr_snap;
    int          resp_snap;

    for (int w = 0; w < 64; w++) begin
      mem_words[w] = $urandom;
      if (w == 4) mem_words[w] = 32'h8899_AABB;
      for (int b = 0; b < 4; b++) ref_mem[4*w+b] = 8'(mem_words[w] >> (8 * b));
    end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_data", mem_data_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    drain();
    chk("word10_after_sh", mem_words[4], 32'h1234_AABB);
    chk("word20_after_sw", mem_words[8], 32'hDEAD_BEEF);

    no_ack = 1'b1;
    issue(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_00AB);
    issue(1'b1, 2'b10, 1'b0, 32'h24, 32'h1357_9BDF);
    drain();
    no_ack = 1'b0;
    chk("ready_after_timeout", 32'(req_ready), 32'd1);

    // Reset while waiting for a slow read ack; the ack then arrives while idle.
    fix_extra = 3;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete(sb.size() - 1);
    #1;
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("midrst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_resp_err", 32'(resp_err), 32'd0);
    chk("midrst_rdata", resp_rdata, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_mem_data", mem_data_o, 32'd0);
    rd_snap = rd_cnt;
    wr_snap = wr_cnt;
    resp_snap = resp_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("postrst_no_resp", 32'(resp_cnt), 32'(resp_snap));
    chk("postrst_no_rd", 32'(rd_cnt), 32'(rd_snap));
    chk("postrst_no_wr", 32'(wr_cnt), 32'(wr_snap));
    chk("postrst_ready", 32'(req_ready), 32'd1);
    fix_extra = 0;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    drain();

    rnd_lat = 1'b1;
    repeat (300) begin
      we  = 1'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 9));
      sz  = (r == 9) ? 2'b11 : 2'(r % 3);
      uns = 1'($urandom_range(0, 1));
      a   = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      wd  = $urandom;
      issue(we, sz, uns, a, wd);
    end
    drain();
    rnd_lat = 1'b0;

    for (int w = 0; w < 64; w++)
      chk("final_mem", mem_words[w], {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
